// File: rtl/fpu_op_sequencer.sv
// fpu_op_sequencer: single-issue controller in front of the FPU add/sub, multiply
// and divide units. It accepts one request, holds the operands on shared registers,
// waits the fixed add/mul latency or the divider done handshake, then returns the
// selected result over a valid/ready response channel.
// Optional feature macro: FPU_SEQ_DIV_TIMEOUT_EN (divider timeout with qNaN + rsp_err).
module fpu_op_sequencer #(
    parameter int ADD_LAT     = 1,
    parameter int MUL_LAT     = 1,
    parameter int DIV_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_funct,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic        add_sub,
    input  logic [31:0] add_result,
    input  logic [31:0] mul_result,
    output logic        div_start,
    input  logic        div_done,
    input  logic [31:0] div_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [1:0]  rsp_funct,
    output logic        rsp_err,
    output logic        busy
);

    localparam int AM_LAT  = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
    localparam int MAX_CNT = (AM_LAT > DIV_TIMEOUT) ? AM_LAT : DIV_TIMEOUT;
    localparam int CW      = $clog2(MAX_CNT + 1);

    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0] ADD_INIT = CW'(ADD_LAT - 1);
    localparam logic [CW-1:0] MUL_INIT = CW'(MUL_LAT - 1);

    localparam logic [1:0] F_ADD = 2'd0;
    localparam logic [1:0] F_SUB = 2'd1;
    localparam logic [1:0] F_DIV = 2'd2;
    localparam logic [1:0] F_MUL = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_EXEC     = 2'd1,
        S_WAIT_DIV = 2'd2,
        S_RESP     = 2'd3
    } state_t;

    state_t         state_r;
    state_t         state_nx_s;
    logic [CW-1:0]  cnt_r;
    logic [1:0]     funct_r;
    logic [31:0]    op_a_r;
    logic [31:0]    op_b_r;
    logic           add_sub_r;
    logic           div_start_r;
    logic [31:0]    rsp_data_r;
    logic [1:0]     rsp_funct_r;
    logic           rsp_valid_r;
    logic           busy_r;

    logic           accept_s;
    logic           exec_done_s;
    logic           div_ok_s;

`ifdef FPU_SEQ_DIV_TIMEOUT_EN
    localparam logic [CW-1:0] DIV_TO = CW'(DIV_TIMEOUT);
    localparam logic [31:0]   QNAN   = 32'h7FC0_0000;
    logic           div_to_s;
    logic           rsp_err_r;
`endif

    // State register; reset overrides any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic and per-state event decode.
    always_comb begin
        state_nx_s  = state_r;
        accept_s    = 1'b0;
        exec_done_s = 1'b0;
        div_ok_s    = 1'b0;
`ifdef FPU_SEQ_DIV_TIMEOUT_EN
        div_to_s    = 1'b0;
`endif
        case (state_r)
            S_IDLE: begin
                if (req_valid) begin
                    accept_s = 1'b1;
                    if (req_funct == F_DIV) begin
                        state_nx_s = S_WAIT_DIV;
                    end else begin
                        state_nx_s = S_EXEC;
                    end
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_EXEC: begin
                if (cnt_r == CNT_ZERO) begin
                    exec_done_s = 1'b1;
                    state_nx_s  = S_RESP;
                end else begin
                    state_nx_s  = S_EXEC;
                end
            end
            S_WAIT_DIV: begin
                // done coincident with the start pulse belongs to no valid operation
                if (div_done && !div_start_r) begin
                    div_ok_s   = 1'b1;
                    state_nx_s = S_RESP;
                end
`ifdef FPU_SEQ_DIV_TIMEOUT_EN
                else if (cnt_r == DIV_TO) begin
                    div_to_s   = 1'b1;
                    state_nx_s = S_RESP;
                end
`endif
                else begin
                    state_nx_s = S_WAIT_DIV;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_nx_s = S_IDLE;
                end else begin
                    state_nx_s = S_RESP;
                end
            end
            default: begin
                state_nx_s = S_IDLE;
            end
        endcase
    end

    // Operand, funct and adder-select capture; held until the next accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a_r    <= 32'h0000_0000;
            op_b_r    <= 32'h0000_0000;
            add_sub_r <= 1'b0;
            funct_r   <= 2'd0;
        end else if (accept_s) begin
            op_a_r    <= req_a;
            op_b_r    <= req_b;
            add_sub_r <= (req_funct == F_SUB);
            funct_r   <= req_funct;
        end else begin
            op_a_r    <= op_a_r;
            op_b_r    <= op_b_r;
            add_sub_r <= add_sub_r;
            funct_r   <= funct_r;
        end
    end

    // Latency countdown in EXEC, saturating elapsed-cycle count in WAIT_DIV.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= CNT_ZERO;
        end else if (accept_s) begin
            case (req_funct)
                F_ADD:   cnt_r <= ADD_INIT;
                F_SUB:   cnt_r <= ADD_INIT;
                F_MUL:   cnt_r <= MUL_INIT;
                default: cnt_r <= CNT_ZERO;
            endcase
        end else if (state_r == S_EXEC && cnt_r != CNT_ZERO) begin
            cnt_r <= cnt_r - CNT_ONE;
        end else if (state_r == S_WAIT_DIV && cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Divider start pulse: exactly the first cycle of WAIT_DIV.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_start_r <= 1'b0;
        end else begin
            div_start_r <= accept_s && (req_funct == F_DIV);
        end
    end

    // Result capture; stays stable through RESP until the next result.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_data_r  <= 32'h0000_0000;
            rsp_funct_r <= 2'd0;
        end else if (exec_done_s) begin
            rsp_data_r  <= (funct_r == F_MUL) ? mul_result : add_result;
            rsp_funct_r <= funct_r;
        end else if (div_ok_s) begin
            rsp_data_r  <= div_result;
            rsp_funct_r <= funct_r;
        end
`ifdef FPU_SEQ_DIV_TIMEOUT_EN
        else if (div_to_s) begin
            rsp_data_r  <= QNAN;
            rsp_funct_r <= funct_r;
        end
`endif
        else begin
            rsp_data_r  <= rsp_data_r;
            rsp_funct_r <= rsp_funct_r;
        end
    end

`ifdef FPU_SEQ_DIV_TIMEOUT_EN
    // Error flag: set only by a divider timeout, cleared by any normal completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_err_r <= 1'b0;
        end else if (div_to_s) begin
            rsp_err_r <= 1'b1;
        end else if (exec_done_s || div_ok_s) begin
            rsp_err_r <= 1'b0;
        end else begin
            rsp_err_r <= rsp_err_r;
        end
    end
    assign rsp_err = rsp_err_r;
`else
    assign rsp_err = 1'b0;
`endif

    // Registered status flags, decoded from the upcoming state.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            rsp_valid_r <= (state_nx_s == S_RESP);
            busy_r      <= (state_nx_s != S_IDLE);
        end
    end

    assign req_ready = (state_r == S_IDLE);
    assign op_a      = op_a_r;
    assign op_b      = op_b_r;
    assign add_sub   = add_sub_r;
    assign div_start = div_start_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign rsp_funct = rsp_funct_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Directed self-checking bench for fpu_op_sequencer (ADD_LAT=1, MUL_LAT=3, DIV_TIMEOUT=64).
// Arithmetic units are modelled by lookup tables of the directed vectors; the
// multiplier result passes through a pipeline so it is only correct after MUL_LAT cycles.
module tb_fpu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_funct;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        add_sub;
    logic [31:0] add_result;
    logic [31:0] mul_result;
    logic        div_start;
    logic        div_done;
    logic [31:0] div_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_funct;
    logic        rsp_err;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    int n_start = 0;
    int cyc;

    logic [31:0] mul_p1 = 32'h0000_0000;
    logic [31:0] mul_p2 = 32'h0000_0000;

    fpu_op_sequencer #(.ADD_LAT(1), .MUL_LAT(3), .DIV_TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_funct(req_funct),
        .req_a(req_a), .req_b(req_b),
        .op_a(op_a), .op_b(op_b), .add_sub(add_sub),
        .add_result(add_result), .mul_result(mul_result),
        .div_start(div_start), .div_done(div_done), .div_result(div_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_funct(rsp_funct), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] add_model(input logic [31:0] a, input logic [31:0] b, input logic sub);
        if (!sub && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        else if (sub && a == 32'h4040_0000 && b == 32'h3F80_0000) return 32'h4000_0000;
        else return 32'hBAD0_BAD0;
    endfunction

    function automatic logic [31:0] mul_model(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
        else return 32'hBAD1_BAD1;
    endfunction

    assign add_result = add_model(op_a, op_b, add_sub);
    assign mul_result = mul_p2;

    always @(posedge clk) begin
        mul_p1 <= mul_model(op_a, op_b);
        mul_p2 <= mul_p1;
    end

    always @(negedge clk) begin
        if (div_start) n_start <= n_start + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
        req_valid = 1'b1;
        req_funct = f;
        req_a     = a;
        req_b     = b;
        check("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_funct = 2'd0; req_a = 32'h0; req_b = 32'h0;
        div_done = 1'b0; div_result = 32'h0; rsp_ready = 1'b1;
        tick(); tick();
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_data", rsp_data, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_op_a", op_a, 32'h0);
        check("rst_div_start", {31'd0, div_start}, 32'd0);
        check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

        // add: response two cycles after accept
        accept(2'd0, 32'h3F80_0000, 32'h4000_0000);
        check("add_c1_busy", {31'd0, busy}, 32'd1);
        check("add_c1_req_ready", {31'd0, req_ready}, 32'd0);
        check("add_c1_op_b", op_b, 32'h4000_0000);
        check("add_c1_add_sub", {31'd0, add_sub}, 32'd0);
        check("add_c1_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        tick();
        check("add_c2_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("add_data", rsp_data, 32'h4040_0000);
        check("add_funct", {30'd0, rsp_funct}, 32'd0);
        check("add_err", {31'd0, rsp_err}, 32'd0);
        tick();
        check("add_done_rsp_valid", {31'd0, rsp_valid}, 32'd0);

        // sub
        accept(2'd1, 32'h4040_0000, 32'h3F80_0000);
        check("sub_add_sub", {31'd0, add_sub}, 32'd1);
        check("sub_c1_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        tick();
        check("sub_add_sub_resp", {31'd0, add_sub}, 32'd1);
        check("sub_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("sub_data", rsp_data, 32'h4000_0000);
        check("sub_funct", {30'd0, rsp_funct}, 32'd1);
        tick();

        // mul: response four cycles after accept
        accept(2'd3, 32'h4000_0000, 32'h4040_0000);
        for (int i = 1; i <= 3; i++) begin
            check("mul_early_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            tick();
        end
        check("mul_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("mul_data", rsp_data, 32'h40C0_0000);
        check("mul_funct", {30'd0, rsp_funct}, 32'd3);
        tick();

        // div: done in the start cycle is ignored; real done 10 cycles after start
        accept(2'd2, 32'h40C0_0000, 32'h4000_0000);
        check("div_start_pulse", {31'd0, div_start}, 32'd1);
        div_done = 1'b1; div_result = 32'hDEAD_BEEF;
        tick();
        div_done = 1'b0;
        for (int i = 2; i <= 10; i++) begin
            check("div_wait_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            check("div_wait_start_low", {31'd0, div_start}, 32'd0);
            tick();
        end
        div_done = 1'b1; div_result = 32'h4040_0000;
        rsp_ready = 1'b0;
        tick();
        div_done = 1'b0; div_result = 32'h1234_5678;
        check("div_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("div_data", rsp_data, 32'h4040_0000);
        check("div_funct", {30'd0, rsp_funct}, 32'd2);
        check("div_err", {31'd0, rsp_err}, 32'd0);
        check("div_start_count", n_start, 32'd1);

        // stall in RESP with a competing request
        req_valid = 1'b1; req_funct = 2'd0; req_a = 32'h1111_1111; req_b = 32'h2222_2222;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("stall_data", rsp_data, 32'h4040_0000);
            check("stall_req_ready", {31'd0, req_ready}, 32'd0);
            check("stall_op_a", op_a, 32'h40C0_0000);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        check("stall_release_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("stall_release_req_ready", {31'd0, req_ready}, 32'd1);
        tick();
        check("idle_busy", {31'd0, busy}, 32'd0);

        // reset mid WAIT_DIV
        accept(2'd2, 32'h40C0_0000, 32'h4000_0000);
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_req_ready", {31'd0, req_ready}, 32'd1);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("midrst_rsp_data", rsp_data, 32'h0);
        check("midrst_div_start", {31'd0, div_start}, 32'd0);
        div_done = 1'b1; div_result = 32'h4040_0000;
        tick(); tick();
        check("midrst_late_done_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("midrst_late_done_busy", {31'd0, busy}, 32'd0);
        div_done = 1'b0;

`ifdef FPU_SEQ_DIV_TIMEOUT_EN
        // timeout: counter hits 64 in the 65th WAIT_DIV cycle, response the cycle after
        accept(2'd2, 32'h40C0_0000, 32'h4000_0000);
        cyc = 1;
        while (!rsp_valid && cyc < 200) begin
            tick();
            cyc++;
        end
        check("to_latency", cyc, 32'd66);
        check("to_data", rsp_data, 32'h7FC0_0000);
        check("to_err", {31'd0, rsp_err}, 32'd1);
        check("to_funct", {30'd0, rsp_funct}, 32'd2);
        tick();
        check("to_done_rsp_valid", {31'd0, rsp_valid}, 32'd0);
`else
        // without timeout the divider is waited on indefinitely
        accept(2'd2, 32'h40C0_0000, 32'h4000_0000);
        cyc = 1;
        while (!rsp_valid && cyc < 100) begin
            tick();
            cyc++;
        end
        check("nto_still_waiting", {31'd0, rsp_valid}, 32'd0);
        check("nto_busy", {31'd0, busy}, 32'd1);
        div_done = 1'b1; div_result = 32'h4040_0000;
        tick();
        div_done = 1'b0;
        check("nto_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("nto_data", rsp_data, 32'h4040_0000);
        check("nto_err", {31'd0, rsp_err}, 32'd0);
        tick();
        check("nto_done_rsp_valid", {31'd0, rsp_valid}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
